// File: rtl/cmd_bus_pkg.sv
// Shared definitions for the command bus: widths, FSM encodings, timeout
// read-data pattern and the latched command record.
package cmd_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/cmd_bus_arbiter_rr.sv
// Round-robin selector: first requester at or after ptr_i (wrapping) wins,
// returned as a one-hot grant.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o
);

    logic [PTR_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest request overwrites.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr_i) + k) % NREQ);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_bus_arbiter.sv
// Round-robin arbiter driving a shared single-transaction command bus.
// Define CMD_BUS_TIMEOUT_EN to add the RWAIT timeout counter and rsp_err.
module cmd_bus_arbiter
    import cmd_bus_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      cmd_bus_addr,
    output logic [DATA_W-1:0]      cmd_bus_data,
    output logic                   cmd_bus_en,
    output logic                   cmd_bus_rd,
    output logic                   cmd_bus_wr,
    input  logic [DATA_W-1:0]      cmd_bus_rdata,
    input  logic                   cmd_bus_rvalid
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("cmd_bus_arbiter: NREQ or TIMEOUT out of range");
    end

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   win_q, win_d;
    cmd_t              cmd_q, cmd_d;
    logic              en_q, en_d, rd_q, rd_d, wr_q, wr_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  win_idx;
    logic              accept;
`ifdef CMD_BUS_TIMEOUT_EN
    logic [15:0]       cnt_q, cnt_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout;

    assign timeout = (cnt_q == 16'(TIMEOUT - 1));
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) win_idx = PTR_W'(i);
        end
    end

    assign accept    = (state_q == S_IDLE) && (|req_valid);
    // Reset forces IDLE, so the accept pulse must also be masked by rst_n.
    assign req_ready = (accept && rst_n) ? grant : '0;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cmd_d       = cmd_q;
        en_d        = 1'b0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
`ifdef CMD_BUS_TIMEOUT_EN
        rsp_err_d   = 1'b0;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_DRIVE;
                    win_d      = grant;
                    ptr_d      = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    cmd_d.wr   = req_wr[win_idx];
                    cmd_d.addr = req_addr[win_idx*ADDR_W +: ADDR_W];
                    cmd_d.data = req_data[win_idx*DATA_W +: DATA_W];
                    en_d       = 1'b1;
                    wr_d       = req_wr[win_idx];
                    rd_d       = ~req_wr[win_idx];
                end
            end
            S_DRIVE: begin
                if (cmd_q.wr) begin
                    state_d     = S_RESP;
                    rsp_valid_d = win_q;
                end else begin
                    state_d = S_RWAIT;
`ifdef CMD_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_RWAIT: begin
                if (cmd_bus_rvalid) begin
                    state_d     = S_RESP;
                    rsp_valid_d = win_q;
                    rsp_data_d  = cmd_bus_rdata;
`ifdef CMD_BUS_TIMEOUT_EN
                end else if (timeout) begin
                    state_d     = S_RESP;
                    rsp_valid_d = win_q;
                    rsp_data_d  = ERR_DATA;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cmd_q       <= '0;
            en_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef CMD_BUS_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cmd_q       <= cmd_d;
            en_q        <= en_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef CMD_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_bus_addr = cmd_q.addr;
    assign cmd_bus_data = cmd_q.data;
    assign cmd_bus_en   = en_q;
    assign cmd_bus_rd   = rd_q;
    assign cmd_bus_wr   = wr_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Self-checking bench for cmd_bus_arbiter: vector table of single transactions,
// response scoreboard, and hand sequences for arbitration and reset corners.
module tb_cmd_bus_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid, req_wr, req_ready, rsp_valid;
    logic [63:0]   req_addr;
    logic [127:0]  req_data;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [15:0]   cmd_bus_addr;
    logic [31:0]   cmd_bus_data;
    logic          cmd_bus_en, cmd_bus_rd, cmd_bus_wr;
    logic [31:0]   cmd_bus_rdata;
    logic          cmd_bus_rvalid;

    typedef struct {
        int          idx;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          rdelay;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        err;
        int          exp_cyc;
    } rsp_t;

    vec_t vecs[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    cmd_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .cmd_bus_addr   (cmd_bus_addr),
        .cmd_bus_data   (cmd_bus_data),
        .cmd_bus_en     (cmd_bus_en),
        .cmd_bus_rd     (cmd_bus_rd),
        .cmd_bus_wr     (cmd_bus_wr),
        .cmd_bus_rdata  (cmd_bus_rdata),
        .cmd_bus_rvalid (cmd_bus_rvalid)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic vec_t mk_vec(int idx, logic wr, logic [15:0] addr, logic [31:0] data,
                                    logic [31:0] rdata, int rdelay, logic [31:0] exp_data,
                                    logic exp_err);
        vec_t v;
        v.idx = idx; v.wr = wr; v.addr = addr; v.data = data;
        v.rdata = rdata; v.rdelay = rdelay; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic push_rsp(input logic [3:0] valid, input logic [31:0] data, input logic err,
                            input int exp_cyc);
        rsp_t e;
        e.valid = valid; e.data = data; e.err = err; e.exp_cyc = exp_cyc;
        rsp_q.push_back(e);
    endtask

    // Called at a sample point where rsp_valid is non-zero.
    task automatic sb_pop(input string nm);
        rsp_t e;
        if (rsp_q.size() == 0) begin
            check({nm, "_unexpected_rsp"}, 64'(rsp_valid), 64'd0);
        end else begin
            e = rsp_q.pop_front();
            check({nm, "_rsp_valid"}, 64'(rsp_valid), 64'(e.valid));
            check({nm, "_rsp_data"},  64'(rsp_data),  64'(e.data));
            check({nm, "_rsp_err"},   64'(rsp_err),   64'(e.err));
            check({nm, "_rsp_cycle"}, 64'(cyc),       64'(e.exp_cyc));
        end
    endtask

    task automatic wait_ready(input logic [3:0] oh, input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready !== 4'b0) got = 1'b1;
            else tick();
        end
        check({nm, "_ready"}, 64'(req_ready), 64'(oh));
    endtask

    // Waits (bounded) for the next response, then checks it is a one-cycle pulse.
    task automatic wait_rsp(input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0) begin
                seen = 1'b1;
                sb_pop(nm);
            end
            tick();
        end
        check({nm, "_rsp_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        check({nm, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
        tick();
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [3:0] oh;
        int t;
        oh = 4'b0001 << v.idx;
        req_wr[v.idx] = v.wr;
        req_addr[v.idx*16 +: 16] = v.addr;
        req_data[v.idx*32 +: 32] = v.data;
        req_valid = oh;
        wait_ready(oh, nm);
        t = cyc;
        if (v.wr)              push_rsp(oh, 32'h0, 1'b0, t + 2);
        else if (v.rdelay > 0) push_rsp(oh, v.exp_data, v.exp_err, t + 2 + v.rdelay);
        else                   push_rsp(oh, v.exp_data, v.exp_err, t + 2 + TMO);
        tick();
        req_valid = '0;
        req_addr  = '1;
        req_data  = '1;
        @(negedge clk);
        check({nm, "_strobe"}, 64'({cmd_bus_en, cmd_bus_wr, cmd_bus_rd}), 64'({1'b1, v.wr, ~v.wr}));
        check({nm, "_bus_addr"}, 64'(cmd_bus_addr), 64'(v.addr));
        check({nm, "_bus_data"}, 64'(cmd_bus_data), 64'(v.data));
        if (!v.wr) begin
            for (int k = 1; k <= v.rdelay; k++) begin
                tick();
                if (k == v.rdelay) begin
                    cmd_bus_rvalid = 1'b1;
                    cmd_bus_rdata  = v.rdata;
                end
                @(negedge clk);
                check({nm, "_rwait_quiet"}, 64'({cmd_bus_en, rsp_valid}), 64'd0);
            end
        end
        tick();
        cmd_bus_rvalid = 1'b0;
        cmd_bus_rdata  = '0;
        wait_rsp(nm);
    endtask

    // Holds the masked requesters high with writes from reset release and
    // expects five grants in the given order, spaced three cycles apart.
    task automatic stream(input logic [3:0] mask, input int o0, input int o1, input int o2,
                          input int o3, input int o4, input string nm);
        int ord[5];
        int n = 0;
        int last_g = -1;
        int last_en = -1;
        int gidx = 0;
        ord = '{o0, o1, o2, o3, o4};
        rst_n = 1'b0;
        req_valid = '0;
        rsp_q.delete();
        tick();
        tick();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*16 +: 16] = 16'h0100 + 16'(i);
            req_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        end
        req_wr    = 4'hF;
        req_valid = mask;
        rst_n     = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (req_ready !== 4'b0) begin
                if (n < 5) begin
                    check({nm, "_grant"}, 64'(req_ready), 64'(4'b0001 << ord[n]));
                    if (last_g >= 0) check({nm, "_grant_gap"}, 64'(cyc - last_g), 64'd3);
                    gidx = ord[n];
                    push_rsp(4'b0001 << ord[n], 32'h0, 1'b0, cyc + 2);
                    last_g = cyc;
                    n++;
                end else begin
                    check({nm, "_extra_grant"}, 64'(req_ready), 64'd0);
                end
            end
            if (cmd_bus_en) begin
                if (last_en >= 0) check({nm, "_strobe_gap"}, 64'(cyc - last_en), 64'd3);
                check({nm, "_strobe_addr"}, 64'(cmd_bus_addr), 64'(16'h0100 + 16'(gidx)));
                check({nm, "_strobe_wr"}, 64'({cmd_bus_wr, cmd_bus_rd}), 64'b10);
                last_en = cyc;
            end
            if (rsp_valid !== 4'b0) sb_pop(nm);
            tick();
            if (n == 5) req_valid = '0;
        end
        check({nm, "_grant_count"}, 64'(n), 64'd5);
        check({nm, "_drained"}, 64'(rsp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n          = 1'b1;
        req_valid      = '0;
        req_wr         = '0;
        req_addr       = '0;
        req_data       = '0;
        cmd_bus_rdata  = '0;
        cmd_bus_rvalid = 1'b0;

        // Reset: outputs cleared and no accept pulse even with requests pending.
        #2;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        check("reset_ctrl", 64'({req_ready, rsp_valid, rsp_err, cmd_bus_en, cmd_bus_rd,
                                 cmd_bus_wr, cmd_bus_addr}), 64'd0);
        check("reset_data", {rsp_data, cmd_bus_data}, 64'd0);
        tick();
        tick();
        req_valid = '0;
        rst_n     = 1'b1;

        vecs.push_back(mk_vec(0, 1'b1, 16'h0012, 32'h0000_00FF, 32'h0, 0, 32'h0, 1'b0));
        vecs.push_back(mk_vec(2, 1'b0, 16'h0040, 32'h0, 32'h1234_5678, 3, 32'h1234_5678, 1'b0));
        vecs.push_back(mk_vec(3, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'h0, 0, 32'h0, 1'b0));
        vecs.push_back(mk_vec(1, 1'b0, 16'h0000, 32'hA5A5_5A5A, 32'h8000_0001, 1, 32'h8000_0001, 1'b0));
        vecs.push_back(mk_vec(0, 1'b0, 16'h8000, 32'h0, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 1'b0));
`ifdef CMD_BUS_TIMEOUT_EN
        // rvalid on the timeout cycle wins; then a read that times out.
        vecs.push_back(mk_vec(2, 1'b0, 16'h0777, 32'h0, 32'h0BAD_F00D, TMO, 32'h0BAD_F00D, 1'b0));
        vecs.push_back(mk_vec(1, 1'b0, 16'h0888, 32'h0, 32'h5555_AAAA, 0, 32'hDEAD_BEEF, 1'b1));
`else
        // No timeout: a long read wait still completes normally.
        vecs.push_back(mk_vec(2, 1'b0, 16'h0777, 32'h0, 32'h0BAD_F00D, 30, 32'h0BAD_F00D, 1'b0));
`endif

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stray rvalid outside RWAIT produces nothing and leaves the block idle.
        cmd_bus_rvalid = 1'b1;
        cmd_bus_rdata  = 32'hBAD0_0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray_rvalid", 64'({rsp_valid, req_ready, cmd_bus_en}), 64'd0);
            tick();
        end
        cmd_bus_rvalid = 1'b0;
        run_vec(mk_vec(3, 1'b1, 16'h0303, 32'h3030_3030, 32'h0, 0, 32'h0, 1'b0), "post_stray");

        stream(4'b1111, 0, 1, 2, 3, 0, "all4");
        stream(4'b0101, 0, 2, 0, 2, 0, "pair02");

        // Reset while a read sits in RWAIT: outputs clear at once, req1 wins first.
        req_wr[2] = 1'b0;
        req_addr[32 +: 16] = 16'h0040;
        req_valid = 4'b0100;
        wait_ready(4'b0100, "abort_rd");
        tick();
        req_valid = '0;
        tick();
        tick();
        req_wr[1] = 1'b1;
        req_addr[16 +: 16] = 16'h0101;
        req_data[32 +: 32] = 32'h1111_2222;
        req_valid = 4'b0010;
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", 64'({req_ready, rsp_valid, rsp_err, cmd_bus_en, cmd_bus_rd,
                                 cmd_bus_wr, cmd_bus_addr}), 64'd0);
        check("abort_data", {rsp_data, cmd_bus_data}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("after_abort_ready", 64'(req_ready), 64'b0010);
        push_rsp(4'b0010, 32'h0, 1'b0, cyc + 2);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("after_abort_strobe", 64'({cmd_bus_en, cmd_bus_wr, cmd_bus_rd}), 64'b110);
        check("after_abort_addr", 64'(cmd_bus_addr), 64'h0101);
        tick();
        wait_rsp("after_abort");
        check("final_drained", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_bus_arbiter.md
CMD_BUS_ARBITER -- requirements
Module: cmd_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 255, read-wait cycle limit (1..65535).
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  NREQ  per-requester transaction request.
REQ-006 Port req_wr  input  NREQ  per-requester direction: 1 write, 0 read.
REQ-007 Port req_addr  input  NREQ*16  per-requester bus address, requester i at [16i+15:16i].
REQ-008 Port req_data  input  NREQ*32  per-requester write data, requester i at [32i+31:32i].
REQ-009 Port req_ready  output  NREQ  one-hot accept pulse.
REQ-010 Port rsp_valid  output  NREQ  one-hot completion pulse.
REQ-011 Port rsp_data  output  32  read data, valid with rsp_valid.
REQ-012 Port rsp_err  output  1  read timeout flag, valid with rsp_valid.
REQ-013 Ports cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_rd, cmd_bus_wr  output  16/32/1/1/1  shared chip bus; all registered.
REQ-014 Ports cmd_bus_rdata, cmd_bus_rvalid  input  32/1  read return from bus slaves.

Function
REQ-015 States are IDLE, DRIVE, RWAIT and RESP.
- IDLE -> DRIVE when any req_valid is high.
- DRIVE -> RESP on a write.
- DRIVE -> RWAIT on a read.
- RWAIT -> RESP on cmd_bus_rvalid, or on timeout.
- RESP -> IDLE.
REQ-016 In IDLE with any req_valid high, the block shall select one winner round-robin and latch that winner's addr, data and wr.
- Round-robin search starts at the index after the last granted requester (index 0 after reset) and wraps at NREQ-1.
- req_ready[winner] is a combinational pulse asserted in that same cycle.
REQ-017 In DRIVE, cmd_bus_en and exactly one of cmd_bus_wr/cmd_bus_rd shall be high for exactly one cycle; strobes are low in every other state.
REQ-018 cmd_bus_addr and cmd_bus_data shall hold the latched command from DRIVE until the next accept.
REQ-019 Cycle-level timing, with acceptance in cycle t:
- bus strobe occurs in cycle t+1;
- a write asserts rsp_valid[winner] in cycle t+2;
- a read asserts rsp_valid[winner] in the cycle after cmd_bus_rvalid is sampled in RWAIT.
REQ-020 rsp_valid shall be a one-cycle pulse; rsp_data holds cmd_bus_rdata for reads and 0 for writes.
REQ-021 cmd_bus_rvalid outside RWAIT shall be ignored.
REQ-022 Requesters dropping req_valid after acceptance shall not affect the in-flight transaction.
REQ-023 Minimum back-to-back spacing shall be 3 cycles per write (IDLE-DRIVE-RESP); no accept occurs outside IDLE.
REQ-024 A requester with req_valid held high shall not be granted again while any other requester is pending.

Reset
REQ-025 On rst_n low, state shall be IDLE and the round-robin pointer shall select requester 0 first.
- All cmd_bus_* outputs, rsp_valid, rsp_data and rsp_err are 0.
- req_ready is 0 while rst_n is low.
REQ-026 Reset mid-transaction shall abort it with no rsp_valid issued.

Configuration
REQ-027 With CMD_BUS_TIMEOUT_EN defined, a 16-bit counter shall run in RWAIT.
- When the counter reaches TIMEOUT with no rvalid, the block moves to RESP with rsp_err=1 and rsp_data=32'hDEAD_BEEF.
- If rvalid arrives in the same cycle as the timeout, rvalid wins and rsp_err=0.
REQ-028 Without CMD_BUS_TIMEOUT_EN, RWAIT shall wait indefinitely, rsp_err shall be tied 0, and no counter shall exist.

Structure
REQ-029 Shared package cmd_bus_pkg shall hold the following, reused by the command scheduler:
- ADDR_W=16 and DATA_W=32;
- state encodings;
- ERR_DATA=32'hDEAD_BEEF.
REQ-030 Round-robin selection shall be a sub-module rr_arbiter (request vector and pointer in, one-hot grant out).

Verification
REQ-031 Single write: req0 addr 16'h0012, data 32'h0000_00FF -> req_ready[0] at t, en+wr with those values at t+1, rsp_valid[0] at t+2.
REQ-032 Single read: req2 addr 16'h0040, rvalid with 32'h1234_5678 three cycles after the strobe -> rsp_valid[2] with rsp_data=32'h1234_5678 and rsp_err=0.
REQ-033 All four requesting writes continuously from reset -> grant order 0,1,2,3,0, with exactly one bus strobe per 3 cycles.
REQ-034 Timeout: CMD_BUS_TIMEOUT_EN defined, TIMEOUT=8, read with no rvalid -> rsp_err=1 and rsp_data=32'hDEAD_BEEF; a stray rvalid afterwards is ignored.
REQ-035 Reset asserted in RWAIT -> all outputs 0 immediately; after release, req1 alone is granted in the first IDLE cycle.
